otter_ex_unit: RTL and testbench



---
 rtl/otter_ex_unit.sv | 128 ++++++++++++
 tb/tb_otter_ex_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/otter_ex_unit.sv
// OTTER RV32I execute stage: operand select, ALU, branch compare, target generation,
// PC-source select and the EX/MEM result register.
module otter_ex_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic [6:0]  OPCODE,
    input  logic [2:0]  FUNCT3,
    input  logic [3:0]  ALU_FUN,
    input  logic        ALU_SRC_A,
    input  logic [1:0]  ALU_SRC_B,
    input  logic [31:0] RS1,
    input  logic [31:0] RS2,
    input  logic [31:0] IMM,
    input  logic [31:0] PC,
    output logic [31:0] ALU_RESULT,
    output logic        BR_EQ,
    output logic        BR_LT,
    output logic        BR_LTU,
    output logic [31:0] JAL,
    output logic [31:0] JALR,
    output logic [31:0] BRANCH,
    output logic [2:0]  PC_SOURCE,
    output logic [31:0] RESULT_Q,
    output logic        VALID_Q
);

    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [2:0] PcSrcNext   = 3'd0;
    localparam logic [2:0] PcSrcJalr   = 3'd1;
    localparam logic [2:0] PcSrcBranch = 3'd2;
    localparam logic [2:0] PcSrcJal    = 3'd3;

    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  shamt;
    logic        br_taken;
    logic [31:0] result_d;
    logic        valid_d;

    always_comb begin
        src_a = ALU_SRC_A ? IMM : RS1;
        case (ALU_SRC_B)
            2'd0:    src_b = RS2;
            2'd1:    src_b = IMM;
            2'd2:    src_b = IMM;
            default: src_b = PC;
        endcase
    end

    assign shamt = src_b[4:0];

    always_comb begin
        ALU_RESULT = 32'h0;
        case (ALU_FUN)
            4'b0000: ALU_RESULT = src_a + src_b;
            4'b1000: ALU_RESULT = src_a - src_b;
            4'b0001: ALU_RESULT = src_a << shamt;
            4'b0010: ALU_RESULT = {31'h0, $signed(src_a) < $signed(src_b)};
            4'b0011: ALU_RESULT = {31'h0, src_a < src_b};
            4'b0100: ALU_RESULT = src_a ^ src_b;
            4'b0101: ALU_RESULT = src_a >> shamt;
            4'b1101: ALU_RESULT = $signed(src_a) >>> shamt;
            4'b0110: ALU_RESULT = src_a | src_b;
            4'b0111: ALU_RESULT = src_a & src_b;
            4'b1001: ALU_RESULT = src_a;
            default: ALU_RESULT = 32'h0;
        endcase
    end

    assign BR_EQ  = (RS1 == RS2);
    assign BR_LT  = ($signed(RS1) < $signed(RS2));
    assign BR_LTU = (RS1 < RS2);

    assign JAL    = PC + IMM;
    assign BRANCH = PC + IMM;
    assign JALR   = (RS1 + IMM) & 32'hFFFF_FFFE;

    always_comb begin
        br_taken = 1'b0;
        case (FUNCT3)
            3'b000:  br_taken = BR_EQ;
            3'b001:  br_taken = !BR_EQ;
            3'b100:  br_taken = BR_LT;
            3'b101:  br_taken = !BR_LT;
            3'b110:  br_taken = BR_LTU;
            3'b111:  br_taken = !BR_LTU;
            default: br_taken = 1'b0;
        endcase
    end

    // A squashed instruction must never redirect fetch; targets stay live regardless.
    always_comb begin
        PC_SOURCE = PcSrcNext;
        if (!FLUSH) begin
            case (OPCODE)
                OpJal:    PC_SOURCE = PcSrcJal;
                OpJalr:   PC_SOURCE = PcSrcJalr;
                OpBranch: PC_SOURCE = br_taken ? PcSrcBranch : PcSrcNext;
                default:  PC_SOURCE = PcSrcNext;
            endcase
        end
    end

    always_comb begin
        result_d = ALU_RESULT;
        valid_d  = !FLUSH;
        if (STALL) begin
            result_d = 32'h0;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            RESULT_Q <= 32'h0;
            VALID_Q  <= 1'b0;
        end else begin
            RESULT_Q <= result_d;
            VALID_Q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_otter_ex_unit.sv
// Self-checking bench for otter_ex_unit: directed cases plus a randomized sweep,
// with registered results tracked through an expected-value queue.
module tb_otter_ex_unit;

    logic        CLK = 1'b0;
    logic        RST, STALL, FLUSH;
    logic [6:0]  OPCODE;
    logic [2:0]  FUNCT3;
    logic [3:0]  ALU_FUN;
    logic        ALU_SRC_A;
    logic [1:0]  ALU_SRC_B;
    logic [31:0] RS1, RS2, IMM, PC;
    logic [31:0] ALU_RESULT, JAL, JALR, BRANCH, RESULT_Q;
    logic        BR_EQ, BR_LT, BR_LTU, VALID_Q;
    logic [2:0]  PC_SOURCE;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [32:0] exp_q[$];

    otter_ex_unit dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
        .OPCODE(OPCODE), .FUNCT3(FUNCT3), .ALU_FUN(ALU_FUN),
        .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B),
        .RS1(RS1), .RS2(RS2), .IMM(IMM), .PC(PC),
        .ALU_RESULT(ALU_RESULT), .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU),
        .JAL(JAL), .JALR(JALR), .BRANCH(BRANCH), .PC_SOURCE(PC_SOURCE),
        .RESULT_Q(RESULT_Q), .VALID_Q(VALID_Q)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Push the expected register contents, clock once, then pop and compare.
    task automatic cycle(input logic rst, input logic stall, input logic flush,
                         input logic [31:0] alu_exp);
        logic [32:0] e;
        RST = rst; STALL = stall; FLUSH = flush;
        if (rst || stall) exp_q.push_back({1'b0, 32'h0});
        else              exp_q.push_back({!flush, alu_exp});
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check_val("RESULT_Q", RESULT_Q, e[31:0]);
        check_val("VALID_Q", {31'h0, VALID_Q}, {31'h0, e[32]});
        RST = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] fn, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        int unsigned sh;
        sa = a;
        sh = b % 32;
        if (fn == 4'h0) return a + b;
        if (fn == 4'h8) return a + ~b + 32'd1;
        if (fn == 4'h1) return a * (32'd1 << sh);
        if (fn == 4'h2) return (sa < $signed(b)) ? 32'd1 : 32'd0;
        if (fn == 4'h3) return (a < b) ? 32'd1 : 32'd0;
        if (fn == 4'h4) return (a | b) & ~(a & b);
        if (fn == 4'h5) return a / (32'd1 << sh);
        if (fn == 4'hD) return sa >>> sh;
        if (fn == 4'h6) return a | b;
        if (fn == 4'h7) return a & b;
        if (fn == 4'h9) return a;
        return 32'h0;
    endfunction

    function automatic logic [2:0] pcsrc_model(input logic [6:0] op, input logic [2:0] f3,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input logic flush);
        logic t;
        if (flush) return 3'd0;
        if (op == 7'b1101111) return 3'd3;
        if (op == 7'b1100111) return 3'd1;
        if (op != 7'b1100011) return 3'd0;
        case (f3)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) < $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a < b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t ? 3'd2 : 3'd0;
    endfunction

    initial begin
        logic [31:0] opa, opb, exp_alu;
        logic [6:0]  ops [4] = '{7'b1100011, 7'b1101111, 7'b1100111, 7'b0110011};
        RST = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
        OPCODE = 7'b0110011; FUNCT3 = 3'b000; ALU_FUN = 4'b0000;
        ALU_SRC_A = 1'b0; ALU_SRC_B = 2'd0;
        RS1 = 32'h0; RS2 = 32'h0; IMM = 32'h0; PC = 32'h0;
        #2;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // ADD overflow wraps, SUB underflow wraps
        RS1 = 32'h7FFF_FFFF; RS2 = 32'h1; ALU_FUN = 4'b0000; #1;
        check_val("add", ALU_RESULT, 32'h8000_0000);
        cycle(1'b0, 1'b0, 1'b0, 32'h8000_0000);
        RS1 = 32'h0; RS2 = 32'h1; ALU_FUN = 4'b1000; #1;
        check_val("sub", ALU_RESULT, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);

        RS1 = 32'h8000_0000; RS2 = 32'h24;
        ALU_FUN = 4'b1101; #1; check_val("sra", ALU_RESULT, 32'hF800_0000);
        ALU_FUN = 4'b0101; #1; check_val("srl", ALU_RESULT, 32'h0800_0000);
        ALU_FUN = 4'b0001; #1; check_val("sll", ALU_RESULT, 32'h0);
        RS2 = 32'h1;
        ALU_FUN = 4'b0010; #1; check_val("slt", ALU_RESULT, 32'h1);
        ALU_FUN = 4'b0011; #1; check_val("sltu", ALU_RESULT, 32'h0);
        ALU_FUN = 4'b1010; #1; check_val("badfun", ALU_RESULT, 32'h0);

        ALU_SRC_A = 1'b1; IMM = 32'h1234_5000; ALU_FUN = 4'b1001; #1;
        check_val("lui", ALU_RESULT, 32'h1234_5000);
        ALU_SRC_B = 2'd3; PC = 32'h100; ALU_FUN = 4'b0000; #1;
        check_val("auipc", ALU_RESULT, 32'h1234_5100);
        cycle(1'b0, 1'b0, 1'b0, 32'h1234_5100);
        ALU_SRC_A = 1'b0; ALU_SRC_B = 2'd0;

        OPCODE = 7'b1100011; RS1 = 32'hFFFF_FFFF; RS2 = 32'h1;
        PC = 32'h200; IMM = 32'hFFFF_FFF8;
        FUNCT3 = 3'b100; #1;
        check_val("blt_src", {29'h0, PC_SOURCE}, 32'd2);
        check_val("flags", {29'h0, BR_EQ, BR_LT, BR_LTU}, 32'b010);
        check_val("br_tgt", BRANCH, 32'h1F8);
        FUNCT3 = 3'b110; #1;
        check_val("bltu_src", {29'h0, PC_SOURCE}, 32'd0);
        FUNCT3 = 3'b010; #1;
        check_val("bad_f3", {29'h0, PC_SOURCE}, 32'd0);
        FUNCT3 = 3'b100; FLUSH = 1'b1; #1;
        check_val("flush_src", {29'h0, PC_SOURCE}, 32'd0);
        check_val("flush_tgt", BRANCH, 32'h1F8);
        FLUSH = 1'b0;

        OPCODE = 7'b1100111; RS1 = 32'h1001; IMM = 32'h4; #1;
        check_val("jalr_tgt", JALR, 32'h1004);
        check_val("jalr_src", {29'h0, PC_SOURCE}, 32'd1);
        OPCODE = 7'b1101111; PC = 32'h40; IMM = 32'h20; #1;
        check_val("jal_tgt", JAL, 32'h60);
        check_val("jal_src", {29'h0, PC_SOURCE}, 32'd3);

        // Register control: ALU_RESULT held at 5
        OPCODE = 7'b0110011; RS1 = 32'h2; RS2 = 32'h3; ALU_FUN = 4'b0000; #1;
        check_val("five", ALU_RESULT, 32'h5);
        cycle(1'b0, 1'b0, 1'b0, 32'h5);
        cycle(1'b0, 1'b1, 1'b0, 32'h5);
        cycle(1'b0, 1'b0, 1'b1, 32'h5);
        cycle(1'b0, 1'b1, 1'b1, 32'h5);
        cycle(1'b0, 1'b0, 1'b0, 32'h5);
        cycle(1'b1, 1'b0, 1'b0, 32'h5);

        for (int i = 0; i < 60; i++) begin
            RS1 = $urandom; RS2 = (i % 5 == 0) ? RS1 : $urandom;
            IMM = $urandom; PC = $urandom;
            ALU_FUN = 4'($urandom); ALU_SRC_A = 1'($urandom); ALU_SRC_B = 2'($urandom);
            OPCODE = ops[$urandom_range(0, 3)]; FUNCT3 = 3'($urandom);
            FLUSH = ($urandom_range(0, 4) == 0);
            opa = ALU_SRC_A ? IMM : RS1;
            opb = (ALU_SRC_B == 2'd0) ? RS2 : ((ALU_SRC_B == 2'd3) ? PC : IMM);
            exp_alu = alu_model(ALU_FUN, opa, opb);
            #1;
            check_val("r_alu", ALU_RESULT, exp_alu);
            check_val("r_pcsrc", {29'h0, PC_SOURCE},
                      {29'h0, pcsrc_model(OPCODE, FUNCT3, RS1, RS2, FLUSH)});
            check_val("r_jalr", JALR, {RS1 + IMM} & ~32'h1);
            check_val("r_jal", JAL, PC + IMM);
            cycle(1'b0, ($urandom_range(0, 5) == 0), FLUSH, exp_alu);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
